// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_ctrl
// Purpose  : Transmit-side sequencer. Pops one byte at a time from the TX
//            FIFO, hands it to the UART transmitter with a one-cycle start
//            pulse, waits for the frame to finish (guarded by a watchdog),
//            counts completed frames and optionally idles between frames.
// Options  : CTS_FLOW_EN - when defined, cts_n is synchronised (2 flops,
//            reset to "not clear") and gates the start of new frames. When
//            undefined, cts_n is ignored and the link is always clear.
// Ports    : clk, rst (async, active high)
//            enable        in   allow new frames to start
//            cts_n         in   clear-to-send, active low, asynchronous
//            fifo_empty    in   TX FIFO empty flag
//            fifo_rd_en    out  TX FIFO read strobe (one cycle per byte)
//            fifo_rd_data  in   TX FIFO data, valid the cycle after a read
//            tx_start      out  one-cycle frame start pulse
//            tx_data       out  byte for the transmitter, held until reload
//            tx_busy       in   transmitter busy
//            tx_done       in   one-cycle frame complete pulse
//            ctrl_busy     out  high whenever the sequencer is not idle
//            frame_cnt     out  16-bit wrapping completed-frame counter
//            timeout_err   out  one-cycle pulse when the watchdog expires
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl #(
  parameter int DATA_WD    = 8,
  parameter int GAP_CYCLES = 0,
  parameter int TIMEOUT    = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               cts_n,
  input  logic               fifo_empty,
  output logic               fifo_rd_en,
  input  logic [DATA_WD-1:0] fifo_rd_data,
  output logic               tx_start,
  output logic [DATA_WD-1:0] tx_data,
  input  logic               tx_busy,
  input  logic               tx_done,
  output logic               ctrl_busy,
  output logic [15:0]        frame_cnt,
  output logic               timeout_err
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SEND  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  // Counter widths leave headroom so the terminal values always fit.
  localparam int WD_W  = $clog2(TIMEOUT + 2);
  localparam int GAP_W = $clog2(GAP_CYCLES + 2);
  localparam bit WD_EN  = (TIMEOUT > 0);
  localparam bit GAP_EN = (GAP_CYCLES > 0);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t             state_q, state_d;
  logic               fifo_rd_en_q, fifo_rd_en_d;
  logic               tx_start_q, tx_start_d;
  logic [DATA_WD-1:0] tx_data_q, tx_data_d;
  logic               ctrl_busy_q, ctrl_busy_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               timeout_err_q, timeout_err_d;
  logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

  logic cts_clear;
  logic start_ok;
  logic done_seen;
  logic wd_fire;

  // --------------------------------------------------------------------------
  // Clear-to-send
  // --------------------------------------------------------------------------
`ifdef CTS_FLOW_EN
  logic cts_meta_q;
  logic cts_sync_q;

  // Flops reset to 1 so nothing starts until the far end has been seen clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      cts_meta_q <= cts_n;
      cts_sync_q <= cts_meta_q;
    end
  end

  assign cts_clear = ~cts_sync_q;
`else
  logic unused_cts_n;
  assign unused_cts_n = cts_n;
  assign cts_clear    = 1'b1;
`endif

  assign start_ok  = enable && !fifo_empty && !tx_busy && cts_clear;
  // tx_start_q is high exactly in the first SEND cycle, where a stale
  // tx_done from the previous frame must not be taken as completion.
  assign done_seen = tx_done && !tx_start_q;
  assign wd_fire   = WD_EN && (wd_cnt_q == WD_LAST);

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    tx_data_d     = tx_data_q;
    frame_cnt_d   = frame_cnt_q;
    timeout_err_d = 1'b0;
    wd_cnt_d      = wd_cnt_q;
    gap_cnt_d     = gap_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        tx_data_d = fifo_rd_data;
        wd_cnt_d  = '0;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        wd_cnt_d = wd_cnt_q + 1'b1;
        // Completion takes priority over a watchdog expiry in the same cycle.
        if (done_seen) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          gap_cnt_d   = '0;
          state_d     = GAP_EN ? ST_GAP : ST_IDLE;
        end else if (wd_fire) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered copies of the decode of the next state, so they
    // line up with the state they belong to without any input-to-output path.
    fifo_rd_en_d = (state_d == ST_FETCH);
    tx_start_d   = (state_q == ST_LOAD);
    ctrl_busy_d  = (state_d != ST_IDLE);
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      fifo_rd_en_q  <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      ctrl_busy_q   <= 1'b0;
      frame_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
      wd_cnt_q      <= '0;
      gap_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      fifo_rd_en_q  <= fifo_rd_en_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      ctrl_busy_q   <= ctrl_busy_d;
      frame_cnt_q   <= frame_cnt_d;
      timeout_err_q <= timeout_err_d;
      wd_cnt_q      <= wd_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
    end
  end

  assign fifo_rd_en  = fifo_rd_en_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign ctrl_busy   = ctrl_busy_q;
  assign frame_cnt   = frame_cnt_q;
  assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_ctrl
// Purpose  : Directed self-checking bench for uart_tx_ctrl. Instance dut_a
//            runs with no inter-frame gap and a 20-cycle watchdog; dut_b runs
//            with a 4-cycle gap and the watchdog disabled. Each has its own
//            small FIFO model with registered read data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

  localparam int DW = 8;
`ifdef CTS_FLOW_EN
  localparam int CTS_LAT = 2;
`else
  localparam int CTS_LAT = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst    = 1'b1;
  logic enable = 1'b0;
  logic cts_n  = 1'b0;

  logic          fifo_empty_a, fifo_rd_en_a, tx_start_a, ctrl_busy_a, timeout_err_a;
  logic          tx_busy_a = 1'b0;
  logic          tx_done_a = 1'b0;
  logic [DW-1:0] fifo_rd_data_a = '0;
  logic [DW-1:0] tx_data_a;
  logic [15:0]   frame_cnt_a;

  logic          fifo_empty_b, fifo_rd_en_b, tx_start_b, ctrl_busy_b, timeout_err_b;
  logic          tx_busy_b = 1'b0;
  logic          tx_done_b = 1'b0;
  logic [DW-1:0] fifo_rd_data_b = '0;
  logic [DW-1:0] tx_data_b;
  logic [15:0]   frame_cnt_b;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] mem_a [16];
  logic [DW-1:0] mem_b [16];
  int wp_a = 0, rp_a = 0, wp_b = 0, rp_b = 0;
  logic [DW-1:0] exp_b [3] = '{8'hA1, 8'hB2, 8'hC3};

  assign fifo_empty_a = (wp_a == rp_a);
  assign fifo_empty_b = (wp_b == rp_b);

  always @(posedge clk) begin
    if (fifo_rd_en_a) begin
      fifo_rd_data_a <= mem_a[rp_a % 16];
      rp_a           <= rp_a + 1;
    end
    if (fifo_rd_en_b) begin
      fifo_rd_data_b <= mem_b[rp_b % 16];
      rp_b           <= rp_b + 1;
    end
  end

  uart_tx_ctrl #(.DATA_WD(DW), .GAP_CYCLES(0), .TIMEOUT(20)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .cts_n(cts_n),
    .fifo_empty(fifo_empty_a), .fifo_rd_en(fifo_rd_en_a), .fifo_rd_data(fifo_rd_data_a),
    .tx_start(tx_start_a), .tx_data(tx_data_a), .tx_busy(tx_busy_a), .tx_done(tx_done_a),
    .ctrl_busy(ctrl_busy_a), .frame_cnt(frame_cnt_a), .timeout_err(timeout_err_a)
  );

  uart_tx_ctrl #(.DATA_WD(DW), .GAP_CYCLES(4), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .cts_n(cts_n),
    .fifo_empty(fifo_empty_b), .fifo_rd_en(fifo_rd_en_b), .fifo_rd_data(fifo_rd_data_b),
    .tx_start(tx_start_b), .tx_data(tx_data_b), .tx_busy(tx_busy_b), .tx_done(tx_done_b),
    .ctrl_busy(ctrl_busy_b), .frame_cnt(frame_cnt_b), .timeout_err(timeout_err_b)
  );

  task automatic push_a(input logic [DW-1:0] d);
    mem_a[wp_a % 16] = d;
    wp_a = wp_a + 1;
  endtask

  task automatic push_b(input logic [DW-1:0] d);
    mem_b[wp_b % 16] = d;
    wp_b = wp_b + 1;
  endtask

  // Reset values, then release and let the link settle.
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++; if (fifo_rd_en_a !== 1'b0) begin n_err++; $display("FAIL rst_rd_en: got %b want 0", fifo_rd_en_a); end
    n_vec++; if (tx_start_a !== 1'b0) begin n_err++; $display("FAIL rst_tx_start: got %b want 0", tx_start_a); end
    n_vec++; if (tx_data_a !== 8'h00) begin n_err++; $display("FAIL rst_tx_data: got %h want 00", tx_data_a); end
    n_vec++; if (ctrl_busy_a !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", ctrl_busy_a); end
    n_vec++; if (frame_cnt_a !== 16'h0000) begin n_err++; $display("FAIL rst_frame_cnt: got %h want 0000", frame_cnt_a); end
    n_vec++; if (timeout_err_a !== 1'b0) begin n_err++; $display("FAIL rst_timeout: got %b want 0", timeout_err_a); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_vec++; if (ctrl_busy_b !== 1'b0) begin n_err++; $display("FAIL rst_idle_b: got %b want 0", ctrl_busy_b); end
  endtask

  // Enable/busy gating, then start latency and a 10-cycle frame, no gap.
  task automatic test_start_latency();
    tx_busy_a = 1'b1;
    push_a(8'h55);
    repeat (2) @(negedge clk);
    n_vec++; if (fifo_rd_en_a !== 1'b0) begin n_err++; $display("FAIL lat_gate_enable: got %b want 0", fifo_rd_en_a); end
    enable = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (fifo_rd_en_a !== 1'b0) begin n_err++; $display("FAIL lat_gate_busy: got %b want 0", fifo_rd_en_a); end
    tx_busy_a = 1'b0;                 // cycle N
    @(negedge clk);                   // N+1
    n_vec++; if (fifo_rd_en_a !== 1'b1) begin n_err++; $display("FAIL lat_rd_en: got %b want 1", fifo_rd_en_a); end
    n_vec++; if (ctrl_busy_a !== 1'b1) begin n_err++; $display("FAIL lat_busy: got %b want 1", ctrl_busy_a); end
    @(negedge clk);                   // N+2
    n_vec++; if (fifo_rd_en_a !== 1'b0) begin n_err++; $display("FAIL lat_rd_en_once: got %b want 0", fifo_rd_en_a); end
    n_vec++; if (tx_start_a !== 1'b0) begin n_err++; $display("FAIL lat_start_early: got %b want 0", tx_start_a); end
    @(negedge clk);                   // N+3
    n_vec++; if (tx_start_a !== 1'b1) begin n_err++; $display("FAIL lat_start: got %b want 1", tx_start_a); end
    n_vec++; if (tx_data_a !== 8'h55) begin n_err++; $display("FAIL lat_data: got %h want 55", tx_data_a); end
    @(negedge clk);                   // N+4
    n_vec++; if (tx_start_a !== 1'b0) begin n_err++; $display("FAIL lat_start_pulse: got %b want 0", tx_start_a); end
    repeat (9) @(negedge clk);        // N+13
    n_vec++; if (frame_cnt_a !== 16'd0) begin n_err++; $display("FAIL lat_cnt_before: got %h want 0000", frame_cnt_a); end
    tx_done_a = 1'b1;
    @(negedge clk);                   // N+14
    tx_done_a = 1'b0;
    n_vec++; if (frame_cnt_a !== 16'd1) begin n_err++; $display("FAIL lat_cnt: got %h want 0001", frame_cnt_a); end
    n_vec++; if (ctrl_busy_a !== 1'b0) begin n_err++; $display("FAIL lat_idle: got %b want 0", ctrl_busy_a); end
    n_vec++; if (tx_data_a !== 8'h55) begin n_err++; $display("FAIL lat_data_hold: got %h want 55", tx_data_a); end
  endtask

  // Three queued bytes with a 4-cycle gap: next read 6 cycles after tx_done.
  task automatic test_gap();
    push_b(8'hA1); push_b(8'hB2); push_b(8'hC3);   // cycle N
    @(negedge clk);                                 // F = N+1
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (fifo_rd_en_b !== 1'b1) begin n_err++; $display("FAIL gap_rd_en[%0d]: got %b want 1", i, fifo_rd_en_b); end
      repeat (2) @(negedge clk);                    // F+2
      n_vec++; if (tx_start_b !== 1'b1) begin n_err++; $display("FAIL gap_start[%0d]: got %b want 1", i, tx_start_b); end
      n_vec++; if (tx_data_b !== exp_b[i]) begin n_err++; $display("FAIL gap_data[%0d]: got %h want %h", i, tx_data_b, exp_b[i]); end
      repeat (3) @(negedge clk);                    // M = F+5
      tx_done_b = 1'b1;
      @(negedge clk);                               // M+1
      tx_done_b = 1'b0;
      n_vec++; if (frame_cnt_b !== 16'(i + 1)) begin n_err++; $display("FAIL gap_cnt[%0d]: got %h want %h", i, frame_cnt_b, 16'(i + 1)); end
      n_vec++; if (ctrl_busy_b !== 1'b1) begin n_err++; $display("FAIL gap_busy_first[%0d]: got %b want 1", i, ctrl_busy_b); end
      repeat (3) @(negedge clk);                    // M+4
      n_vec++; if (ctrl_busy_b !== 1'b1) begin n_err++; $display("FAIL gap_busy_last[%0d]: got %b want 1", i, ctrl_busy_b); end
      @(negedge clk);                               // M+5
      n_vec++; if (ctrl_busy_b !== 1'b0) begin n_err++; $display("FAIL gap_idle[%0d]: got %b want 0", i, ctrl_busy_b); end
      n_vec++; if (fifo_rd_en_b !== 1'b0) begin n_err++; $display("FAIL gap_rd_early[%0d]: got %b want 0", i, fifo_rd_en_b); end
      @(negedge clk);                               // M+6
    end
    n_vec++; if (fifo_rd_en_b !== 1'b0) begin n_err++; $display("FAIL gap_rd_empty: got %b want 0", fifo_rd_en_b); end
    n_vec++; if (frame_cnt_b !== 16'd3) begin n_err++; $display("FAIL gap_cnt_final: got %h want 0003", frame_cnt_b); end
  endtask

  // Watchdog expiry, then next byte, then done and expiry in the same cycle.
  task automatic test_timeout();
    push_a(8'h3C); push_a(8'h7E);     // cycle N
    repeat (3) @(negedge clk);        // S = N+3
    n_vec++; if (tx_data_a !== 8'h3C) begin n_err++; $display("FAIL to_data: got %h want 3c", tx_data_a); end
    repeat (19) @(negedge clk);       // S+19
    n_vec++; if (timeout_err_a !== 1'b0) begin n_err++; $display("FAIL to_early: got %b want 0", timeout_err_a); end
    n_vec++; if (ctrl_busy_a !== 1'b1) begin n_err++; $display("FAIL to_busy: got %b want 1", ctrl_busy_a); end
    @(negedge clk);                   // S+20
    n_vec++; if (timeout_err_a !== 1'b1) begin n_err++; $display("FAIL to_pulse: got %b want 1", timeout_err_a); end
    n_vec++; if (ctrl_busy_a !== 1'b0) begin n_err++; $display("FAIL to_idle: got %b want 0", ctrl_busy_a); end
    n_vec++; if (frame_cnt_a !== 16'd1) begin n_err++; $display("FAIL to_cnt: got %h want 0001", frame_cnt_a); end
    @(negedge clk);                   // S+21
    n_vec++; if (timeout_err_a !== 1'b0) begin n_err++; $display("FAIL to_pulse_width: got %b want 0", timeout_err_a); end
    n_vec++; if (fifo_rd_en_a !== 1'b1) begin n_err++; $display("FAIL to_next_rd: got %b want 1", fifo_rd_en_a); end
    repeat (2) @(negedge clk);        // S2 = S+23
    n_vec++; if (tx_data_a !== 8'h7E) begin n_err++; $display("FAIL to_next_data: got %h want 7e", tx_data_a); end
    repeat (19) @(negedge clk);       // S2+19: done on the expiry cycle
    tx_done_a = 1'b1;
    @(negedge clk);                   // S2+20
    tx_done_a = 1'b0;
    n_vec++; if (timeout_err_a !== 1'b0) begin n_err++; $display("FAIL to_tie_err: got %b want 0", timeout_err_a); end
    n_vec++; if (frame_cnt_a !== 16'd2) begin n_err++; $display("FAIL to_tie_cnt: got %h want 0002", frame_cnt_a); end
  endtask

  // Asynchronous reset mid-frame; the popped byte is lost, next byte goes out.
  task automatic test_reset_in_send();
    push_a(8'h11); push_a(8'h22);     // cycle N
    repeat (3) @(negedge clk);        // N+3
    n_vec++; if (tx_data_a !== 8'h11) begin n_err++; $display("FAIL rs_data: got %h want 11", tx_data_a); end
    @(negedge clk);                   // N+4, second SEND cycle
    rst = 1'b1;
    #1;
    n_vec++; if (ctrl_busy_a !== 1'b0) begin n_err++; $display("FAIL rs_busy: got %b want 0", ctrl_busy_a); end
    n_vec++; if (tx_data_a !== 8'h00) begin n_err++; $display("FAIL rs_data_clr: got %h want 00", tx_data_a); end
    n_vec++; if (frame_cnt_a !== 16'd0) begin n_err++; $display("FAIL rs_cnt: got %h want 0000", frame_cnt_a); end
    @(negedge clk);
    rst = 1'b0;                       // cycle R
    repeat (1 + CTS_LAT) @(negedge clk);
    n_vec++; if (fifo_rd_en_a !== 1'b1) begin n_err++; $display("FAIL rs_rd_en: got %b want 1", fifo_rd_en_a); end
    repeat (2) @(negedge clk);
    n_vec++; if (tx_start_a !== 1'b1) begin n_err++; $display("FAIL rs_start: got %b want 1", tx_start_a); end
    n_vec++; if (tx_data_a !== 8'h22) begin n_err++; $display("FAIL rs_next_data: got %h want 22", tx_data_a); end
    repeat (2) @(negedge clk);
    tx_done_a = 1'b1;
    @(negedge clk);
    tx_done_a = 1'b0;
    n_vec++; if (frame_cnt_a !== 16'd1) begin n_err++; $display("FAIL rs_cnt_after: got %h want 0001", frame_cnt_a); end
  endtask

  // Frame counter wraps from 0xFFFF to 0x0000.
  task automatic test_wrap();
    @(negedge clk);
    force dut_a.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut_a.frame_cnt_q;
    @(negedge clk);
    n_vec++; if (frame_cnt_a !== 16'hFFFF) begin n_err++; $display("FAIL wrap_preload: got %h want ffff", frame_cnt_a); end
    push_a(8'h99);
    repeat (3) @(negedge clk);
    n_vec++; if (tx_start_a !== 1'b1) begin n_err++; $display("FAIL wrap_start: got %b want 1", tx_start_a); end
    repeat (2) @(negedge clk);
    tx_done_a = 1'b1;
    @(negedge clk);
    tx_done_a = 1'b0;
    n_vec++; if (frame_cnt_a !== 16'h0000) begin n_err++; $display("FAIL wrap_cnt: got %h want 0000", frame_cnt_a); end
  endtask

`ifdef CTS_FLOW_EN
  // Flow control: blocked while not clear, 3-cycle start after clearing,
  // and a frame in flight is not aborted by cts going away.
  task automatic test_cts();
    cts_n = 1'b1;
    repeat (3) @(negedge clk);
    push_a(8'h5A);
    repeat (4) @(negedge clk);
    n_vec++; if (fifo_rd_en_a !== 1'b0) begin n_err++; $display("FAIL cts_block: got %b want 0", fifo_rd_en_a); end
    n_vec++; if (ctrl_busy_a !== 1'b0) begin n_err++; $display("FAIL cts_idle: got %b want 0", ctrl_busy_a); end
    cts_n = 1'b0;                     // cycle C
    repeat (2) @(negedge clk);        // C+2
    n_vec++; if (fifo_rd_en_a !== 1'b0) begin n_err++; $display("FAIL cts_rd_early: got %b want 0", fifo_rd_en_a); end
    @(negedge clk);                   // C+3
    n_vec++; if (fifo_rd_en_a !== 1'b1) begin n_err++; $display("FAIL cts_rd_en: got %b want 1", fifo_rd_en_a); end
    repeat (2) @(negedge clk);        // C+5
    n_vec++; if (tx_data_a !== 8'h5A) begin n_err++; $display("FAIL cts_data: got %h want 5a", tx_data_a); end
    @(negedge clk);
    cts_n = 1'b1;                     // not clear mid-SEND
    repeat (2) @(negedge clk);
    tx_done_a = 1'b1;
    @(negedge clk);
    tx_done_a = 1'b0;
    n_vec++; if (frame_cnt_a !== 16'd1) begin n_err++; $display("FAIL cts_cnt: got %h want 0001", frame_cnt_a); end
    cts_n = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_start_latency();
    test_gap();
    test_timeout();
    test_reset_in_send();
    test_wrap();
`ifdef CTS_FLOW_EN
    test_cts();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
